// File: rtl/sr_bank.sv
// Bank of CH registered set/reset channels with per-channel force-to-zero,
// selectable S/R conflict policy, sticky conflict flags and a one-channel-per-cycle init sweep.
module sr_bank #(
  parameter int             CH            = 8,
  parameter logic [CH-1:0]  INIT_VAL      = {CH{1'b0}},
  parameter int             CONFLICT_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] s,
  input  logic [CH-1:0] r,
  input  logic [CH-1:0] force0,
  input  logic          init_req,
  input  logic          conflict_clr,
  output logic [CH-1:0] q,
  output logic          busy,
  output logic          done,
  output logic [CH-1:0] conflict
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CH-1:0]    q_next;
  logic [CH-1:0]    conflict_next;
  logic             idle;

  assign idle = (state == IDLE);

  // Per-channel next state: force0 beats the sweep write, which beats S/R.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic sweep_hit;
    logic sr_val;

    assign sweep_hit = (state == SWEEP) && (idx == IDX_W'(gi));

    always_comb begin
      sr_val = q[gi];
      case ({s[gi], r[gi]})
        2'b10:   sr_val = 1'b1;
        2'b01:   sr_val = 1'b0;
        2'b11: begin
          if (CONFLICT_MODE == 1)      sr_val = 1'b1;
          else if (CONFLICT_MODE == 2) sr_val = 1'b0;
          else                         sr_val = q[gi];
        end
        default: sr_val = q[gi];
      endcase
    end

    assign q_next[gi] = force0[gi] ? 1'b0 :
                        sweep_hit  ? INIT_VAL[gi] :
                        idle       ? sr_val :
                                     q[gi];

    // A fresh conflict on the same edge as a clear keeps the flag set.
    assign conflict_next[gi] = (idle && !force0[gi] && s[gi] && r[gi]) ||
                               (conflict[gi] && !conflict_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= INIT_VAL;
      conflict <= '0;
    end else begin
      q        <= q_next;
      conflict <= conflict_next;
    end
  end

  // Sweep sequencer; init_req is only looked at in IDLE, so a request held
  // through the done cycle starts the next sweep one edge after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_req) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank.sv
// Self-checking bench for sr_bank: three instances (one per conflict policy) fed the same
// stimulus, checked against a behavioural model plus directed vectors and sequences.
module tb_sr_bank;
  localparam int          CH = 8;
  localparam logic [7:0]  IV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s = '0, r = '0, force0 = '0;
  logic       init_req = 1'b0, conflict_clr = 1'b0;
  logic [7:0] q [3];
  logic [7:0] conflict [3];
  logic       busy [3];
  logic       done [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sr_bank #(.CH(CH), .INIT_VAL(IV), .CONFLICT_MODE(gi)) u_dut (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .force0(force0),
      .init_req(init_req), .conflict_clr(conflict_clr),
      .q(q[gi]), .busy(busy[gi]), .done(done[gi]), .conflict(conflict[gi])
    );
  end

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: channel arrays plus a sweep position counter
  logic [7:0] mq [3];
  logic [7:0] mc [3];
  bit         sweeping;
  bit         mdone;
  int         sweep_pos;
  logic [7:0] iv_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      mq[m] = IV;
      mc[m] = '0;
    end
    sweeping  = 0;
    mdone     = 0;
    sweep_pos = 0;
  endfunction

  function automatic void model_step();
    iv_v = IV;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < CH; k++) begin
        bit cur;
        bit nxt;
        cur = mq[m][k];
        nxt = cur;
        if (force0[k]) nxt = 0;
        else if (sweeping) begin
          if (k == sweep_pos) nxt = iv_v[k];
        end else if (s[k] && !r[k]) nxt = 1;
        else if (r[k] && !s[k]) nxt = 0;
        else if (s[k] && r[k]) begin
          if (m == 1) nxt = 1;
          else if (m == 2) nxt = 0;
        end
        mq[m][k] = nxt;
        mc[m][k] = (!sweeping && !force0[k] && s[k] && r[k]) || (mc[m][k] && !conflict_clr);
      end
    end
    if (sweeping) begin
      sweep_pos++;
      if (sweep_pos == CH) begin
        sweeping = 0;
        mdone    = 1;
      end else begin
        mdone = 0;
      end
    end else begin
      mdone = 0;
      if (init_req) begin
        sweeping  = 1;
        sweep_pos = 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s q mode%0d", tag, m), q[m], mq[m]);
      chk($sformatf("%s conflict mode%0d", tag, m), conflict[m], mc[m]);
      chk($sformatf("%s busy mode%0d", tag, m), busy[m], sweeping);
      chk($sformatf("%s done mode%0d", tag, m), done[m], mdone);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #2;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] f;
    logic       clr;
    logic [7:0] eq0;
    logic [7:0] eq1;
    logic [7:0] eq2;
    logic [7:0] ec;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    bit saw_done;
    logic [7:0] mask;
    logic [7:0] exp_q;

    vt[0] = '{8'h02, 8'h80, 8'h00, 1'b0, 8'h27, 8'h27, 8'h27, 8'h00};
    vt[1] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h27, 8'h27, 8'h27, 8'h00};
    vt[2] = '{8'h08, 8'h08, 8'h00, 1'b0, 8'h27, 8'h2F, 8'h27, 8'h08};
    vt[3] = '{8'h08, 8'h08, 8'h00, 1'b1, 8'h27, 8'h2F, 8'h27, 8'h08};
    vt[4] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h27, 8'h2F, 8'h27, 8'h00};
    vt[5] = '{8'h04, 8'h00, 8'h04, 1'b0, 8'h23, 8'h2B, 8'h23, 8'h00};
    vt[6] = '{8'h10, 8'h10, 8'h10, 1'b0, 8'h23, 8'h2B, 8'h23, 8'h00};
    vt[7] = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    // Reset held from time 0; check values before any released edge
    #12;
    model_reset();
    chk("reset q", q[0], 8'hA5);
    chk("reset busy", busy[0], 1'b0);
    chk("reset done", done[0], 1'b0);
    chk("reset conflict", conflict[0], 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      s = vt[i].s; r = vt[i].r; force0 = vt[i].f; conflict_clr = vt[i].clr;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d q mode0", i), q[0], vt[i].eq0);
      chk($sformatf("vec%0d q mode1", i), q[1], vt[i].eq1);
      chk($sformatf("vec%0d q mode2", i), q[2], vt[i].eq2);
      chk($sformatf("vec%0d conflict", i), conflict[0], vt[i].ec);
    end
    force0 = '0; conflict_clr = 1'b0;

    // Sweep from q=FF, with s/r both all-ones and init_req held while busy
    s = 8'hFF; r = 8'h00; init_req = 1'b1;
    cycle("sweep start");
    busy_cnt = busy[0] ? 1 : 0;
    s = 8'hFF; r = 8'hFF;
    for (int k = 0; k < CH; k++) begin
      cycle($sformatf("sweep k%0d", k));
      mask  = 8'((9'd1 << (k + 1)) - 9'd1);
      exp_q = (8'hFF & ~mask) | (8'hA5 & mask);
      chk($sformatf("sweep q after ch%0d", k), q[0], exp_q);
      if (busy[0]) busy_cnt++;
      if (k == CH - 1) chk("sweep done pulse", done[0], 1'b1);
      else chk($sformatf("sweep no done k%0d", k), done[0], 1'b0);
    end
    chk("sweep busy cycles", busy_cnt, 8);
    chk("sweep no conflict", conflict[0], 8'h00);

    // init_req held across done cycle: new sweep begins at the following edge; ch2 forced
    s = '0; r = '0; force0 = 8'h04;
    cycle("resweep start");
    chk("resweep busy", busy[0], 1'b1);
    chk("resweep done low", done[0], 1'b0);
    init_req = 1'b0;
    for (int k = 0; k < CH; k++) cycle($sformatf("resweep k%0d", k));
    chk("forced sweep q", q[0], 8'hA1);
    chk("forced sweep done", done[0], 1'b1);
    force0 = '0;

    // Reset in the middle of a sweep (idx=4)
    r = 8'hFF;
    cycle("clear all");
    r = '0; init_req = 1'b1;
    cycle("mid start");
    init_req = 1'b0;
    for (int k = 0; k < 4; k++) cycle($sformatf("mid k%0d", k));
    chk("mid sweep q", q[0], 8'h05);
    async_reset("mid reset");
    chk("mid reset q", q[0], 8'hA5);
    chk("mid reset busy", busy[0], 1'b0);
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      cycle($sformatf("post reset %0d", k));
      if (done[0]) saw_done = 1;
    end
    chk("no done after reset", saw_done, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      s = 8'($urandom); r = 8'($urandom);
      force0 = 8'($urandom & $urandom & $urandom);
      init_req = ($urandom_range(0, 15) == 0);
      conflict_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) async_reset($sformatf("rand reset %0d", i));
      cycle($sformatf("rand %0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
